sobel_3x3: RTL and testbench



---
 rtl/sobel_3x3_pkg.sv | 28 ++
 rtl/sobel_3x3_if.sv | 36 +++
 rtl/sobel_3x3_abs.sv | 30 +++
 rtl/sobel_3x3.sv | 72 +++++++
 tb/tb_sobel_3x3.sv | 112 +++++++++++
 5 files changed

// File: rtl/sobel_3x3_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared types and constants for the 3x3 Sobel gradient-magnitude engine.
//
//   PIX_W   : pixel width (8-bit grayscale)
//   GRAD_W  : gradient width; the Sobel sums span +/-1020, so 11-bit
//             two's complement holds them with no truncation
//   PIX_MAX : saturated output pixel value
//   pix_t   : unsigned pixel
//   grad_t  : signed gradient
//   zext()  : widens a pixel to a non-negative gradient operand so that
//             every subtraction in the datapath is carried out at full width
// -----------------------------------------------------------------------------
package sobel_pkg;

   localparam int PIX_W  = 8;
   localparam int GRAD_W = 11;

   typedef logic        [PIX_W-1:0]  pix_t;
   typedef logic signed [GRAD_W-1:0] grad_t;

   localparam pix_t PIX_MAX = 8'd255;

   function automatic grad_t zext(input pix_t p);
      return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
   endfunction

endpackage

// File: rtl/sobel_3x3_if.sv
// -----------------------------------------------------------------------------
// sobel_3x3_if
//   Pixel-window bus between the window generator and the Sobel engine.
//
//   p0 p1 p2 : top row    (left, centre, right)
//   p3    p5 : middle row (left, right); the centre pixel is not used
//   p6 p7 p8 : bottom row (left, centre, right)
//   out      : registered edge magnitude returned by the engine
//
//   master : window generator side (drives the window, reads out)
//   slave  : Sobel engine side     (reads the window, drives out)
// -----------------------------------------------------------------------------
interface sobel_3x3_if;
   import sobel_pkg::*;

   pix_t p0;
   pix_t p1;
   pix_t p2;
   pix_t p3;
   pix_t p5;
   pix_t p6;
   pix_t p7;
   pix_t p8;
   pix_t out;

   modport master (
      output p0, p1, p2, p3, p5, p6, p7, p8,
      input  out
   );

   modport slave (
      input  p0, p1, p2, p3, p5, p6, p7, p8,
      output out
   );

endinterface

// File: rtl/sobel_3x3_abs.sv
// -----------------------------------------------------------------------------
// sobel_abs
//   Absolute value of a signed Sobel gradient.
//
//   grad_i : signed gradient (grad_t)
//   mag_o  : unsigned magnitude, same width as the gradient
//
//   The gradient never reaches the most negative code (-1024), so the
//   two's-complement negation of any legal value (down to -1020) fits
//   without overflow.
// -----------------------------------------------------------------------------
module sobel_abs
   import sobel_pkg::*;
(
   input  grad_t             grad_i,
   output logic [GRAD_W-1:0] mag_o
);

   grad_t neg_grad;

   always_comb begin
      neg_grad = -grad_i;
      if (grad_i[GRAD_W-1]) begin
         mag_o = neg_grad;
      end else begin
         mag_o = grad_i;
      end
   end

endmodule

// File: rtl/sobel_3x3.sv
// -----------------------------------------------------------------------------
// sobel_3x3
//   Single-cycle-latency Sobel gradient-magnitude engine. Each clock it takes
//   a 3x3 window (centre excluded), forms the horizontal and vertical Sobel
//   gradients, and registers the saturated L1 magnitude |gx| + |gy| as an
//   8-bit edge pixel. One result per clock, no handshake, no enable.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears out to 0 immediately
//   win   : window bus (slave side) carrying p0..p8 (no p4) in and out back
//
//   gx = (p2 - p0) + 2*(p5 - p3) + (p8 - p6)
//   gy = (p0 - p6) + 2*(p1 - p7) + (p2 - p8)
// -----------------------------------------------------------------------------
module sobel_3x3
   import sobel_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   sobel_3x3_if.slave   win
);

   grad_t             gx_d;
   grad_t             gy_d;
   logic [GRAD_W-1:0] mag_x;
   logic [GRAD_W-1:0] mag_y;
   logic [GRAD_W-1:0] sum_d;
   pix_t              out_d;
   pix_t              out_q;

   // Centre-column/row weights of 2 are applied as a shift of the difference,
   // which stays within +/-1020 and so never wraps the 11-bit gradient.
   always_comb begin
      gx_d = (zext(win.p2) - zext(win.p0))
           + ((zext(win.p5) - zext(win.p3)) <<< 1)
           + (zext(win.p8) - zext(win.p6));
      gy_d = (zext(win.p0) - zext(win.p6))
           + ((zext(win.p1) - zext(win.p7)) <<< 1)
           + (zext(win.p2) - zext(win.p8));
   end

   sobel_abs u_abs_x (
      .grad_i (gx_d),
      .mag_o  (mag_x)
   );

   sobel_abs u_abs_y (
      .grad_i (gy_d),
      .mag_o  (mag_y)
   );

   // Sum peaks at 2040, which still fits the 11-bit unsigned width.
   always_comb begin
      sum_d = mag_x + mag_y;
      if (|sum_d[GRAD_W-1:PIX_W]) begin
         out_d = PIX_MAX;
      end else begin
         out_d = sum_d[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign win.out = out_q;

endmodule

// File: tb/tb_sobel_3x3.sv
module tb_sobel_3x3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   sobel_3x3_if win_if ();

   sobel_3x3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .win   (win_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_win(input logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8);
      win_if.p0 = a0;
      win_if.p1 = a1;
      win_if.p2 = a2;
      win_if.p3 = a3;
      win_if.p5 = a5;
      win_if.p6 = a6;
      win_if.p7 = a7;
      win_if.p8 = a8;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply a window away from the edge, let one rising edge capture it,
   // then sample shortly after that edge.
   task automatic step(input string tag, input logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8,
                       input logic [7:0] exp);
      @(negedge clk);
      set_win(a0, a1, a2, a3, a5, a6, a7, a8);
      @(posedge clk);
      #1;
      chk(tag, win_if.out, exp);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset with arbitrary inputs: out is 0 before any clock edge.
      rst_n = 1'b0;
      set_win(8'd200, 8'd13, 8'd77, 8'd5, 8'd250, 8'd1, 8'd99, 8'd42);
      #2;
      chk("reset_async_pre_edge", win_if.out, 8'd0);
      @(posedge clk);
      #1;
      chk("reset_held_edge1", win_if.out, 8'd0);
      @(posedge clk);
      #1;
      chk("reset_held_edge2", win_if.out, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_released_no_edge", win_if.out, 8'd0);

      // First edge after release captures the window with no warm-up.
      step("flat_100",      8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0);
      step("p2_10",         8'd0,   8'd0,   8'd10,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd20);
      step("p0_10_abs",     8'd10,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd20);
      step("p1_30",         8'd0,   8'd30,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd60);
      step("p5_100",        8'd0,   8'd0,   8'd0,   8'd0,   8'd100, 8'd0,   8'd0,   8'd0,   8'd200);
      step("p1_30_p5_100",  8'd0,   8'd30,  8'd0,   8'd0,   8'd100, 8'd0,   8'd0,   8'd0,   8'd255);
      step("p5_127",        8'd0,   8'd0,   8'd0,   8'd0,   8'd127, 8'd0,   8'd0,   8'd0,   8'd254);
      step("p5_128",        8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd0,   8'd0,   8'd0,   8'd255);
      // p7 = 50: gy = -100, gx = 0 -> 100 (negative vertical term)
      step("p7_50_neg_gy",  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd50,  8'd0,   8'd100);
      // p3 = 20, p6 = 7: gx = -40 - 7 = -47, gy = -7 -> 54 (both negative)
      step("p3_20_p6_7",    8'd0,   8'd0,   8'd0,   8'd20,  8'd0,   8'd7,   8'd0,   8'd0,   8'd54);
      step("gx_max_1020",   8'd0,   8'd0,   8'd255, 8'd0,   8'd255, 8'd0,   8'd0,   8'd255, 8'd255);
      step("gy_max_1020",   8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255);
      // gx = -1020, gy = 0 -> abs of the most negative reachable gradient
      step("gx_min_-1020",  8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd255, 8'd0,   8'd0,   8'd255);
      // small gradient after saturation: out must drop back
      step("p8_3",          8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd3,   8'd6);

      // Streaming: W0, W1 on consecutive edges, reset pulse, then W2.
      step("stream_w0",     8'd0,   8'd0,   8'd10,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd20);
      step("stream_w1",     8'd0,   8'd30,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd60);
      #2;
      set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0);
      rst_n = 1'b0;
      #1;
      chk("midstream_reset_async", win_if.out, 8'd0);
      @(posedge clk);
      #1;
      chk("midstream_reset_held", win_if.out, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midstream_release_no_edge", win_if.out, 8'd0);
      @(posedge clk);
      #1;
      chk("stream_w2_after_reset", win_if.out, 8'd200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
